rv_instr_loader: RTL and testbench
==================================

# rv_instr_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the write port of the instruction dual-port RAM (`wena`/`strobe`/`addra`/`dina`). The instruction fetch path keeps reading the other port. While a load is in progress the block holds the core in reset.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory depth in 32-bit words.
- `AW`, 8: write address width; must equal clog2(`DEPTH`).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start_i` in 1: restart-load pulse; honoured only in DONE or ERR.
- `byte_valid_i` in 1: stream byte valid.
- `byte_data_i` in 8: stream byte.
- `byte_ready_o` out 1: block can accept a byte.
- `wena_o` out 1: RAM write enable.
- `strobe_o` out 4: RAM byte strobes.
- `addra_o` out AW: RAM write word address.
- `dina_o` out 32: RAM write data.
- `core_hold_o` out 1: holds the core in reset while high.
- `done_o` out 1: one-cycle pulse when a load completes.
- `err_o` out 1: sticky error flag; cleared by `rst` or an accepted `start_i`.

## Operation
- Stream format:
  - Bytes 0–1: word count N, 16-bit little-endian.
  - Then N words of 4 bytes each, little-endian, so byte 0 lands in `dina[7:0]`.
  - With `RV_LOADER_CKSUM_EN` only: one trailing checksum byte.
- Handshake: a byte transfers on any cycle with `byte_valid_i & byte_ready_o`. `byte_ready_o` is 1 in states LEN0, LEN1, DATA and CKSUM, and 0 in DONE and ERR.
- States:
  - LEN0: the transfer captures count[7:0] and moves to LEN1.
  - LEN1: the transfer captures count[15:8].
    - N == 0 goes to DONE (or to CKSUM when the checksum is enabled).
    - N > `DEPTH` goes to ERR.
    - Otherwise goes to DATA.
  - DATA:
    - A 2-bit byte counter fills the word assembly register.
    - When the 4th byte transfers, the write fires, the word index increments and the byte counter wraps to 0.
    - After word N−1 the state moves to DONE (or CKSUM).
  - CKSUM: covered under Configuration.
  - DONE:
    - `core_hold_o` = 0.
    - `start_i` clears the word index, byte counter, count register and checksum register, then moves to LEN0.
  - ERR:
    - `core_hold_o` = 1, `err_o` = 1.
    - `start_i` clears `err_o`, then moves to LEN0 (same clearing as DONE).
- The write address is the word index, 0..N−1; there is no wrap. Because N ≤ `DEPTH` is checked up front, the index never exceeds `DEPTH`−1.
- Memory is not cleared; words at index ≥ N keep their old contents.
- `start_i` in LEN0, LEN1, DATA or CKSUM is ignored.
- `byte_valid_i` while `byte_ready_o` = 0 is ignored; no byte is consumed.

## Timing
- Reset values:
  - State LEN0; a load starts automatically after reset.
  - `byte_ready_o` = 1, `core_hold_o` = 1.
  - `wena_o` = 0, `strobe_o` = 0, `addra_o` = 0, `dina_o` = 0.
  - `done_o` = 0, `err_o` = 0.
- Write latency:
  - The 4th byte of a word transfers in cycle T. In cycle T+1, `wena_o` = 1, `strobe_o` = 4'hF, `addra_o` = word index, `dina_o` = assembled word.
  - In cycle T+2, `wena_o` = 0 and `strobe_o` = 0 unless another write is due.
- Back-to-back bytes at one byte per cycle are supported. A new word's first byte may transfer in the same cycle T+1 as the previous word's write.
- Entering DONE in cycle T:
  - `done_o` = 1 in cycle T+1 only.
  - `core_hold_o` falls in cycle T+1, the same cycle as the last write (N > 0). The RAM captures that write at the end of T+1, so the core's first fetch is no earlier than T+2.
- `err_o` rises the cycle after the offending LEN1 byte.
- `rst` mid-load: the next cycle shows reset values; any partial word is discarded.

## Configuration
- Macro `RV_LOADER_CKSUM_EN`.
- Defined:
  - An 8-bit XOR runs over all data bytes; count bytes are excluded.
  - After the last word (or straight after LEN1 when N == 0) the block enters CKSUM and accepts one byte.
  - If that byte equals the running XOR, go to DONE; otherwise go to ERR.
  - Words already written stay in memory either way.
- Undefined: CKSUM does not exist. The last word goes straight to DONE, and N == 0 goes straight to DONE after LEN1.

## Test plan
- Load N=2 with stream 02 00 13 00 00 00 93 00 10 00 at one byte per cycle:
  - writes (addr 0, 0x00000013) then (addr 1, 0x00100093), each with strobe F.
  - `done_o` pulses once; `core_hold_o` falls in the same cycle as the second write; `err_o` = 0.
- Same load with `byte_valid_i` toggling 1/0 each cycle: identical writes and data; `done_o` pulses once.
- Count 0x0101 (257 > 256):
  - ERR after the 2nd byte; `err_o` = 1, no write, `core_hold_o` = 1, `byte_ready_o` = 0.
  - `start_i` then clears `err_o` and `byte_ready_o` returns to 1.
- `rst` after 2 data bytes, then the full N=1 stream 01 00 EF BE AD DE: a single write (addr 0, 0xDEADBEEF).
- Count N=0:
  - Checksum disabled: DONE directly after byte 2.
  - Checksum enabled: trailing byte 00 gives DONE; trailing byte 01 gives ERR.
- `RV_LOADER_CKSUM_EN`, N=1, data 11 22 33 44:
  - checksum 0x44 gives `done_o` = 1; checksum 0x45 gives `err_o` = 1 and `core_hold_o` stays 1.
  - In both cases the write (addr 0, 0x44332211) occurs.

Source files
------------

// File: rtl/rv_instr_loader.sv
// Boot-time instruction memory loader: byte stream in, 32-bit RAM writes out.
// Optional trailing XOR checksum is enabled with `define RV_LOADER_CKSUM_EN.
module rv_instr_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          wena_o,
  output logic [3:0]    strobe_o,
  output logic [AW-1:0] addra_o,
  output logic [31:0]   dina_o,
  output logic          core_hold_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_e;

`ifdef RV_LOADER_CKSUM_EN
  localparam state_e S_TAIL = S_CKSUM;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e        state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   idx_inc;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   asm_q, asm_d;
  logic          wena_q, wena_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [31:0]   dina_q, dina_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   len_full;
  logic          xfer;
`ifdef RV_LOADER_CKSUM_EN
  logic [7:0]    cksum_q, cksum_d;
`endif

  assign byte_ready_o = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                        (state_q == S_DATA) || (state_q == S_CKSUM);
  assign xfer         = byte_valid_i & byte_ready_o;
  assign len_full     = {byte_data_i, len_lo_q};
  assign idx_inc      = idx_q + 1'b1;

  assign core_hold_o  = (state_q != S_DONE);
  assign wena_o       = wena_q;
  assign strobe_o     = {4{wena_q}};
  assign addra_o      = addra_q;
  assign dina_o       = dina_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    count_d  = count_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    wena_d   = 1'b0;
    addra_d  = addra_q;
    dina_d   = dina_q;
    err_d    = err_q;
`ifdef RV_LOADER_CKSUM_EN
    cksum_d  = cksum_q;
`endif

    case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_lo_d = byte_data_i;
          state_d  = S_LEN1;
        end
      end

      S_LEN1: begin
        if (xfer) begin
          // Oversized counts are rejected here so the write index can never overflow.
          if (len_full == 16'd0) begin
            count_d = '0;
            state_d = S_TAIL;
          end else if (len_full > 16'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            count_d = len_full[AW:0];
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
`ifdef RV_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ byte_data_i;
`endif
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: asm_d[7:0]   = byte_data_i;
            2'd1: asm_d[15:8]  = byte_data_i;
            2'd2: asm_d[23:16] = byte_data_i;
            default: begin
              wena_d  = 1'b1;
              addra_d = idx_q[AW-1:0];
              dina_d  = {byte_data_i, asm_q};
              idx_d   = idx_inc;
              if (idx_inc == count_q) begin
                state_d = S_TAIL;
              end
            end
          endcase
        end
      end

      S_CKSUM: begin
`ifdef RV_LOADER_CKSUM_EN
        if (xfer) begin
          if (byte_data_i == cksum_q) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
`else
        state_d = S_DONE;
`endif
      end

      S_DONE, S_ERR: begin
        if (start_i) begin
          len_lo_d = '0;
          count_d  = '0;
          idx_d    = '0;
          bcnt_d   = '0;
          err_d    = 1'b0;
`ifdef RV_LOADER_CKSUM_EN
          cksum_d  = '0;
`endif
          state_d  = S_LEN0;
        end
      end

      default: state_d = S_LEN0;
    endcase

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LEN0;
      len_lo_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      wena_q   <= 1'b0;
      addra_q  <= '0;
      dina_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef RV_LOADER_CKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      wena_q   <= wena_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef RV_LOADER_CKSUM_EN
      cksum_q  <= cksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv_instr_loader.sv
// Self-checking bench for rv_instr_loader: scoreboard of expected RAM writes.
// Define RV_LOADER_CKSUM_EN for both files to exercise the checksum tail.
module tb_rv_instr_loader;

  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          wena_o;
  logic [3:0]    strobe_o;
  logic [AW-1:0] addra_o;
  logic [31:0]   dina_o;
  logic          core_hold_o;
  logic          done_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int write_cnt = 0;
  int done_cyc = -1;
  int last_write_cyc = -2;
  int d0, w0;

  logic [AW+31:0] sb[$];
  logic [31:0]    words [0:3];
  logic [7:0]     tail_byte;

  rv_instr_loader #(.DEPTH(256), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .wena_o       (wena_o),
    .strobe_o     (strobe_o),
    .addra_o      (addra_o),
    .dina_o       (dina_o),
    .core_hold_o  (core_hold_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every write leaving the DUT must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (wena_o) begin
        write_cnt++;
        last_write_cyc = cyc;
        checkOutput("write_strobe", 40'(strobe_o), 40'hF);
        if (sb.size() == 0) begin
          checkOutput("unexpected_write", {8'(addra_o), dina_o}, 40'h0);
        end else begin
          logic [AW+31:0] e;
          e = sb.pop_front();
          checkOutput("write_addr", 40'(addra_o), 40'(e[AW+31:32]));
          checkOutput("write_data", 40'(dina_o), 40'(e[31:0]));
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        checkOutput("done_hold_low", 40'(core_hold_o), 40'h0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    @(posedge clk);
    @(negedge clk);
    byte_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_load(input logic [15:0] n, input bit gap, input bit bad_ck);
    logic [7:0] ck;
    ck = 8'h00;
    applyStimulus(n[7:0], gap);
    applyStimulus(n[15:8], gap);
    for (int i = 0; i < int'(n); i++) begin
      sb.push_back({8'(i), words[i]});
      for (int b = 0; b < 4; b++) begin
        ck = ck ^ words[i][8*b +: 8];
        applyStimulus(words[i][8*b +: 8], gap);
      end
    end
    tail_byte = bad_ck ? (ck ^ 8'h01) : ck;
`ifdef RV_LOADER_CKSUM_EN
    applyStimulus(tail_byte, gap);
`endif
    $display("[TB] load n=%0d gap=%0d tail=%h", n, gap, tail_byte);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_ready", 40'(byte_ready_o), 40'h1);
    checkOutput("rst_hold", 40'(core_hold_o), 40'h1);
    checkOutput("rst_wena", 40'(wena_o), 40'h0);
    checkOutput("rst_strobe", 40'(strobe_o), 40'h0);
    checkOutput("rst_addra", 40'(addra_o), 40'h0);
    checkOutput("rst_dina", 40'(dina_o), 40'h0);
    checkOutput("rst_done", 40'(done_o), 40'h0);
    checkOutput("rst_err", 40'(err_o), 40'h0);

    $display("[TB] N=2 back-to-back load");
    d0 = done_cnt; w0 = write_cnt;
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    send_load(16'd2, 1'b0, 1'b0);
    idle(3);
    checkOutput("n2_done_pulses", 40'(done_cnt - d0), 40'd1);
    checkOutput("n2_writes", 40'(write_cnt - w0), 40'd2);
    checkOutput("n2_hold_falls_with_last_write", 40'(done_cyc), 40'(last_write_cyc));
    checkOutput("n2_err", 40'(err_o), 40'h0);
    checkOutput("n2_hold", 40'(core_hold_o), 40'h0);
    checkOutput("n2_ready", 40'(byte_ready_o), 40'h0);
    checkOutput("n2_sb_empty", 40'(sb.size()), 40'h0);

    // Bytes offered while not ready must not be consumed.
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hFF;
    idle(3);
    byte_valid_i = 1'b0;
    pulse_start();
    checkOutput("restart_ready", 40'(byte_ready_o), 40'h1);
    checkOutput("restart_hold", 40'(core_hold_o), 40'h1);

    $display("[TB] N=2 load with gaps");
    d0 = done_cnt; w0 = write_cnt;
    send_load(16'd2, 1'b1, 1'b0);
    idle(3);
    checkOutput("gap_done_pulses", 40'(done_cnt - d0), 40'd1);
    checkOutput("gap_writes", 40'(write_cnt - w0), 40'd2);
    checkOutput("gap_sb_empty", 40'(sb.size()), 40'h0);
    pulse_start();

    $display("[TB] oversize count 0x0101");
    d0 = done_cnt; w0 = write_cnt;
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkOutput("ovf_err_next_cycle", 40'(err_o), 40'h1);
    idle(2);
    checkOutput("ovf_err", 40'(err_o), 40'h1);
    checkOutput("ovf_hold", 40'(core_hold_o), 40'h1);
    checkOutput("ovf_ready", 40'(byte_ready_o), 40'h0);
    checkOutput("ovf_writes", 40'(write_cnt - w0), 40'd0);
    checkOutput("ovf_done", 40'(done_cnt - d0), 40'd0);
    pulse_start();
    checkOutput("ovf_err_cleared", 40'(err_o), 40'h0);
    checkOutput("ovf_ready_back", 40'(byte_ready_o), 40'h1);

    $display("[TB] reset mid-load");
    w0 = write_cnt;
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready", 40'(byte_ready_o), 40'h1);
    checkOutput("midrst_hold", 40'(core_hold_o), 40'h1);
    d0 = done_cnt;
    words[0] = 32'hDEAD_BEEF;
    send_load(16'd1, 1'b0, 1'b0);
    idle(3);
    checkOutput("midrst_writes", 40'(write_cnt - w0), 40'd1);
    checkOutput("midrst_done", 40'(done_cnt - d0), 40'd1);
    checkOutput("midrst_sb_empty", 40'(sb.size()), 40'h0);
    pulse_start();

    $display("[TB] N=0 load");
    d0 = done_cnt; w0 = write_cnt;
    send_load(16'd0, 1'b0, 1'b0);
    idle(3);
    checkOutput("n0_done", 40'(done_cnt - d0), 40'd1);
    checkOutput("n0_writes", 40'(write_cnt - w0), 40'd0);
    checkOutput("n0_err", 40'(err_o), 40'h0);
    pulse_start();

`ifdef RV_LOADER_CKSUM_EN
    $display("[TB] N=0 with bad checksum");
    d0 = done_cnt;
    send_load(16'd0, 1'b0, 1'b1);
    idle(3);
    checkOutput("n0bad_err", 40'(err_o), 40'h1);
    checkOutput("n0bad_done", 40'(done_cnt - d0), 40'd0);
    pulse_start();

    $display("[TB] N=1 good checksum");
    d0 = done_cnt; w0 = write_cnt;
    words[0] = 32'h4433_2211;
    send_load(16'd1, 1'b0, 1'b0);
    idle(3);
    checkOutput("ck_tail_value", 40'(tail_byte), 40'h44);
    checkOutput("ckgood_done", 40'(done_cnt - d0), 40'd1);
    checkOutput("ckgood_writes", 40'(write_cnt - w0), 40'd1);
    checkOutput("ckgood_err", 40'(err_o), 40'h0);
    pulse_start();

    $display("[TB] N=1 bad checksum");
    d0 = done_cnt; w0 = write_cnt;
    send_load(16'd1, 1'b0, 1'b1);
    idle(3);
    checkOutput("ckbad_err", 40'(err_o), 40'h1);
    checkOutput("ckbad_hold", 40'(core_hold_o), 40'h1);
    checkOutput("ckbad_done", 40'(done_cnt - d0), 40'd0);
    checkOutput("ckbad_writes", 40'(write_cnt - w0), 40'd1);
    checkOutput("ckbad_sb_empty", 40'(sb.size()), 40'h0);
    pulse_start();
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
